memory_w_pipe_stage: RTL and testbench
======================================

Name: memory_w_pipe_stage

Overview:
- Consumer end of the E->M pipeline register: reads the M_* register outputs and performs the Y86 data-memory access.
- Talks to data memory over a req/ack handshake with variable latency.
- Drives a busy/stall request back to pipeline control.
- Registers the results into the W pipeline register, which feeds write-back and forwarding.

Parameters:
- DMEM_SIZE, 64'd8192, data memory size in bytes; any access with addr >= DMEM_SIZE is an address error.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- M_stat_i  in  3  status from M register.
- M_pc_i  in  64  PC of instruction in M.
- M_icode_i  in  4  icode.
- M_valE_i  in  64  ALU result / memory address.
- M_valA_i  in  64  store data / pop-ret address.
- M_dstE_i  in  4  E destination register.
- M_dstM_i  in  4  M destination register.
- W_stall_i  in  1  hold W register (from pipeline control).
- m_busy_o  out  1  memory access outstanding; control must stall F/D/E/M.
- m_stat_o  out  3  combinational stage status, for control.
- dmem_req_o  out  1  request valid, registered.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  64  byte address.
- dmem_wdata_o  out  64  write data.
- dmem_rdata_i  in  64  read data, valid with ack.
- dmem_ack_i  in  1  access complete.
- dmem_err_i  in  1  bus error, valid with ack.
- W_stat_o  out  3  W register outputs.
- W_pc_o  out  64  W register outputs.
- W_icode_o  out  4  W register outputs.
- W_valE_o  out  64  W register outputs.
- W_valM_o  out  64  W register outputs.
- W_dstE_o  out  4  W register outputs.
- W_dstM_o  out  4  W register outputs.

Behaviour:
- Access decode:
  - Reads: IMRMOVQ (addr = valE), IPOPQ and IRET (addr = valA).
  - Writes: IRMMOVQ, IPUSHQ, ICALL (addr = valE, data = valA).
  - Access is performed only when M_stat_i == SAOK.
- Range check:
  - addr >= DMEM_SIZE: no request issued; m_stat_o = SADR; W loads in one cycle like a non-memory instruction.
- FSM states IDLE, WAIT, DONE:
  - IDLE: if a valid in-range access is pending and !W_stall_i, register req=1 plus we/addr/wdata and go to WAIT.
  - WAIT: dmem_req_o, we, addr and wdata are held stable. On dmem_ack_i, capture rdata and err, drop req on the same edge, go to DONE.
  - DONE: W loads the captured result. Go to IDLE when !W_stall_i, otherwise stay in DONE.
- m_busy_o = (IDLE & access pending) | WAIT | (DONE & W_stall_i). Combinational.
- Minimum occupancy of a memory instruction in M is 3 cycles (ack in the first WAIT cycle).
- m_stat_o = SADR if (out of range or captured err) else M_stat_i.
- W_valM: captured rdata for reads, 0 otherwise.
- W update at each rising edge:
  - W_stall_i: hold.
  - Else if m_busy_o: load bubble (stat SAOK, pc 0, icode INOP, valE/valM 0, dstE/dstM RNONE).
  - Else load stage results.
- Non-memory instructions and non-SAOK M_stat_i pass into W in 1 cycle, with no request.
- Reset value of every output while rst_n_i is low:
  - State IDLE.
  - dmem_req_o = 0, dmem_we_o = 0, dmem_addr_o = 0, dmem_wdata_o = 0.
  - W outputs = bubble value.
- Reset asserted during WAIT: request is withdrawn immediately. Any ack arriving later is ignored, because state is IDLE.
- Ack while in IDLE or DONE: ignored.
- dmem_err_i with ack: no retry; the result goes to W with SADR.
- At most one request outstanding at any time.

Decomposition:
- Constants live in define.v:
  - INOP, RNONE.
  - Icodes IRMMOVQ 4, IMRMOVQ 5, ICALL 8, IRET 9, IPUSHQ A, IPOPQ B.
  - Stat codes SAOK 1, SHLT 2, SADR 3, SINS 4.
  - New MEM_IDLE/MEM_WAIT/MEM_DONE 2-bit state encodings.
- One sub-module: memory_W_pipe_reg, the W register with stall/bubble/async-reset semantics. The FSM and access decode stay in the top module.

Test Plan:
- rmmovq, M_valE=0x100, M_valA=0xDEAD, ack 2 cycles after req -> req/we=1, addr=0x100, wdata=0xDEAD stable until ack; m_busy_o high 4 cycles; W_icode=4, W_stat=SAOK.
- mrmovq, valE=0x200, dstM=3, rdata=0x1234 with ack in first WAIT cycle -> W_valM=0x1234, W_dstM=3; busy exactly 2 cycles, W bubbles meanwhile.
- popq, valA=0x8, valE=0x10 -> read issued at addr 0x8; W_valE=0x10, W_dstE/W_dstM propagate.
- mrmovq with valE=DMEM_SIZE -> no req ever; m_stat_o=SADR; W_stat=SADR next edge; busy never high.
- ack with dmem_err_i=1 -> W_stat=SADR, W_valM captured.
- rst_n_i low mid-WAIT -> req drops asynchronously, W_icode=INOP, busy=0; late ack ignored.
- OPq back-to-back -> one instruction per cycle in W, no req.

Source files
------------

// File: rtl/memory_w_pipe_stage_pkg.sv
// memory_w_pipe_stage_pkg: Y86 constants, FSM encoding and W register record
package memory_w_pipe_stage_pkg;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SHLT    = 3'd2;
    localparam logic [2:0] SADR    = 3'd3;
    localparam logic [2:0] SINS    = 3'd4;
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;
    typedef struct packed {
        logic [2:0]  stat;
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } w_t;
    localparam w_t W_BUBBLE = '{stat: SAOK, pc: 64'd0, icode: INOP, val_e: 64'd0,
                                val_m: 64'd0, dst_e: RNONE, dst_m: RNONE};
    function automatic logic is_read(input logic [3:0] icode);
        return icode inside {IMRMOVQ, IPOPQ, IRET};
    endfunction
    function automatic logic is_write(input logic [3:0] icode);
        return icode inside {IRMMOVQ, IPUSHQ, ICALL};
    endfunction
endpackage

// File: rtl/memory_w_pipe_stage_if.sv
// memory_w_pipe_stage_if: data-memory req/ack bus
interface memory_w_pipe_stage_if;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        ack;
    logic        err;
    modport master (output req, we, addr, wdata, input rdata, ack, err);
    modport slave (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/memory_W_pipe_reg.sv
// memory_W_pipe_reg: W pipeline register with stall, bubble and async reset
module memory_W_pipe_reg
    import memory_w_pipe_stage_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic stall,
    input  logic bubble,
    input  w_t   d,
    output w_t   q
);
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) q <= W_BUBBLE;
        else if (!stall) q <= bubble ? W_BUBBLE : d;
    end
endmodule

// File: rtl/memory_w_pipe_stage.sv
// memory_w_pipe_stage: Y86 memory stage with variable-latency data-memory handshake
module memory_w_pipe_stage
    import memory_w_pipe_stage_pkg::*;
#(
    parameter logic [63:0] DMEM_SIZE = 64'd8192
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [2:0]                    M_stat_i,
    input  logic [63:0]                   M_pc_i,
    input  logic [3:0]                    M_icode_i,
    input  logic [63:0]                   M_valE_i,
    input  logic [63:0]                   M_valA_i,
    input  logic [3:0]                    M_dstE_i,
    input  logic [3:0]                    M_dstM_i,
    input  logic                          W_stall_i,
    output logic                          m_busy_o,
    output logic [2:0]                    m_stat_o,
    memory_w_pipe_stage_if.master         dmem,
    output logic [2:0]                    W_stat_o,
    output logic [63:0]                   W_pc_o,
    output logic [3:0]                    W_icode_o,
    output logic [63:0]                   W_valE_o,
    output logic [63:0]                   W_valM_o,
    output logic [3:0]                    W_dstE_o,
    output logic [3:0]                    W_dstM_o
);
    mem_state_t  state;
    logic [63:0] rdata_q;
    logic        err_q;
    logic        rd, wr, acc, oor, pending;
    logic [63:0] addr;
    w_t          w_d, w_q;

    assign rd      = is_read(M_icode_i);
    assign wr      = is_write(M_icode_i);
    assign acc     = (rd || wr) && M_stat_i == SAOK;
    assign addr    = (M_icode_i == IPOPQ || M_icode_i == IRET) ? M_valA_i : M_valE_i;
    assign oor     = acc && addr >= DMEM_SIZE;
    assign pending = acc && !oor;
    assign m_stat_o = (oor || (state == MEM_DONE && err_q)) ? SADR : M_stat_i;
    // Busy is forced low during reset so control sees an idle stage
    assign m_busy_o = rst_n_i && ((state == MEM_IDLE && pending) || state == MEM_WAIT ||
                                  (state == MEM_DONE && W_stall_i));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= MEM_IDLE;
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: if (pending && !W_stall_i) begin
                    state      <= MEM_WAIT;
                    dmem.req   <= 1'b1;
                    dmem.we    <= wr;
                    dmem.addr  <= addr;
                    dmem.wdata <= wr ? M_valA_i : '0;
                end
                MEM_WAIT: if (dmem.ack) begin
                    state    <= MEM_DONE;
                    dmem.req <= 1'b0;
                    rdata_q  <= dmem.rdata;
                    err_q    <= dmem.err;
                end
                MEM_DONE: if (!W_stall_i) state <= MEM_IDLE;
                default:  state <= MEM_IDLE;
            endcase
        end
    end

    assign w_d = '{stat: m_stat_o, pc: M_pc_i, icode: M_icode_i, val_e: M_valE_i,
                   val_m: (rd && state == MEM_DONE) ? rdata_q : 64'd0,
                   dst_e: M_dstE_i, dst_m: M_dstM_i};

    memory_W_pipe_reg u_w_reg (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .stall  (W_stall_i),
        .bubble (m_busy_o),
        .d      (w_d),
        .q      (w_q)
    );

    assign W_stat_o  = w_q.stat;
    assign W_pc_o    = w_q.pc;
    assign W_icode_o = w_q.icode;
    assign W_valE_o  = w_q.val_e;
    assign W_valM_o  = w_q.val_m;
    assign W_dstE_o  = w_q.dst_e;
    assign W_dstM_o  = w_q.dst_m;
endmodule

// File: tb/tb_memory_w_pipe_stage.sv
// tb_memory_w_pipe_stage: directed vector bench for the memory stage
module tb_memory_w_pipe_stage;
    import memory_w_pipe_stage_pkg::*;
    localparam logic [3:0] IOPQ = 4'h6, IRRMOVQ = 4'h2;
    logic        clk_i = 1'b0, rst_n_i = 1'b0;
    logic [2:0]  M_stat_i;
    logic [63:0] M_pc_i, M_valE_i, M_valA_i;
    logic [3:0]  M_icode_i, M_dstE_i, M_dstM_i;
    logic        W_stall_i, m_busy_o;
    logic [2:0]  m_stat_o, W_stat_o;
    logic [63:0] W_pc_o, W_valE_o, W_valM_o;
    logic [3:0]  W_icode_o, W_dstE_o, W_dstM_o;
    int n_chk = 0, n_fail = 0;

    memory_w_pipe_stage_if dmem();

    memory_w_pipe_stage dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .M_stat_i(M_stat_i), .M_pc_i(M_pc_i),
        .M_icode_i(M_icode_i), .M_valE_i(M_valE_i), .M_valA_i(M_valA_i),
        .M_dstE_i(M_dstE_i), .M_dstM_i(M_dstM_i), .W_stall_i(W_stall_i),
        .m_busy_o(m_busy_o), .m_stat_o(m_stat_o), .dmem(dmem),
        .W_stat_o(W_stat_o), .W_pc_o(W_pc_o), .W_icode_o(W_icode_o),
        .W_valE_o(W_valE_o), .W_valM_o(W_valM_o), .W_dstE_o(W_dstE_o), .W_dstM_o(W_dstM_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] pc, val_e, val_a;
        logic [3:0]  dst_e, dst_m;
        logic [2:0]  exp_stat;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [2:0] stat, input logic [63:0] pc,
                         input logic [3:0] icode, input logic [63:0] val_e, val_m,
                         input logic [3:0] dst_e, dst_m);
        chk({name, ".W_stat"}, W_stat_o, stat);
        chk({name, ".W_pc"}, W_pc_o, pc);
        chk({name, ".W_icode"}, W_icode_o, icode);
        chk({name, ".W_valE"}, W_valE_o, val_e);
        chk({name, ".W_valM"}, W_valM_o, val_m);
        chk({name, ".W_dstE"}, W_dstE_o, dst_e);
        chk({name, ".W_dstM"}, W_dstM_o, dst_m);
    endtask

    task automatic set_m(input logic [2:0] stat, input logic [3:0] icode, input logic [63:0] pc,
                         input logic [63:0] val_e, val_a, input logic [3:0] dst_e, dst_m);
        M_stat_i = stat; M_icode_i = icode; M_pc_i = pc;
        M_valE_i = val_e; M_valA_i = val_a; M_dstE_i = dst_e; M_dstM_i = dst_m;
    endtask

    task automatic nop();
        set_m(SAOK, INOP, 64'd0, 64'd0, 64'd0, RNONE, RNONE);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Runs one memory instruction through M, answering the request dly cycles after it appears
    task automatic mem_case(input string name, input logic [3:0] icode, input logic [63:0] pc,
                            input logic [63:0] val_e, val_a, input logic [3:0] dst_e, dst_m,
                            input int dly, input logic [63:0] rd, input logic e,
                            input logic [63:0] exp_addr, input logic exp_we, input int exp_busy);
        int   busy_cyc = 0;
        int   req_cyc = 0;
        logic done = 1'b0;
        set_m(SAOK, icode, pc, val_e, val_a, dst_e, dst_m);
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (m_busy_o) busy_cyc++;
            if (dmem.req) begin
                chk({name, ".we"}, dmem.we, exp_we);
                chk({name, ".addr"}, dmem.addr, exp_addr);
                if (exp_we) chk({name, ".wdata"}, dmem.wdata, val_a);
                chk({name, ".W_bubble"}, W_icode_o, INOP);
                if (req_cyc == dly) begin
                    dmem.ack = 1'b1; dmem.rdata = rd; dmem.err = e;
                end
                req_cyc++;
            end else if (busy_cyc > 0 && !m_busy_o) begin
                done = 1'b1;
                chk({name, ".m_stat"}, m_stat_o, e ? SADR : SAOK);
            end
            tick();
            dmem.ack = 1'b0; dmem.rdata = '0; dmem.err = 1'b0;
        end
        if (!done) chk({name, ".timeout"}, 64'd0, 64'd1);
        nop();
        chk({name, ".busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
        chk_w(name, e ? SADR : SAOK, pc, icode, val_e, exp_we ? 64'd0 : rd, dst_e, dst_m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{SAOK, IOPQ,    64'h10, 64'h5,    64'h0,    4'h2, RNONE, SAOK};
        vecs[1] = '{SAOK, IOPQ,    64'h12, 64'h9,    64'h0,    4'h3, RNONE, SAOK};
        vecs[2] = '{SAOK, IRRMOVQ, 64'h14, 64'h77,   64'h0,    4'h1, RNONE, SAOK};
        vecs[3] = '{SAOK, IRMMOVQ, 64'h16, 64'h2000, 64'h1,    RNONE, RNONE, SADR};
        vecs[4] = '{SAOK, IMRMOVQ, 64'h20, 64'h2000, 64'h0,    RNONE, 4'h3, SADR};
        vecs[5] = '{SAOK, IPOPQ,   64'h2a, 64'h10,   64'hFFFF_FFFF_FFFF_FFF8, 4'h4, 4'h5, SADR};
        vecs[6] = '{SHLT, IMRMOVQ, 64'h2c, 64'h100,  64'h0,    RNONE, 4'h2, SHLT};
        vecs[7] = '{SINS, IOPQ,    64'h36, 64'h42,   64'h0,    4'h6, RNONE, SINS};
        W_stall_i = 1'b0;
        dmem.ack = 1'b0; dmem.rdata = '0; dmem.err = 1'b0;
        nop();
        tick();
        tick();
        chk("rst.req", dmem.req, 1'b0);
        chk("rst.we", dmem.we, 1'b0);
        chk("rst.addr", dmem.addr, 64'd0);
        chk("rst.wdata", dmem.wdata, 64'd0);
        chk("rst.busy", m_busy_o, 1'b0);
        chk_w("rst", SAOK, 64'd0, INOP, 64'd0, 64'd0, RNONE, RNONE);
        rst_n_i = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            set_m(vecs[i].stat, vecs[i].icode, vecs[i].pc, vecs[i].val_e, vecs[i].val_a,
                  vecs[i].dst_e, vecs[i].dst_m);
            #1;
            chk($sformatf("vec%0d.busy", i), m_busy_o, 1'b0);
            chk($sformatf("vec%0d.m_stat", i), m_stat_o, vecs[i].exp_stat);
            tick();
            chk($sformatf("vec%0d.req", i), dmem.req, 1'b0);
            chk_w($sformatf("vec%0d", i), vecs[i].exp_stat, vecs[i].pc, vecs[i].icode,
                  vecs[i].val_e, 64'd0, vecs[i].dst_e, vecs[i].dst_m);
        end

        W_stall_i = 1'b1;
        set_m(SAOK, IMRMOVQ, 64'h40, 64'h200, 64'h0, RNONE, 4'h3);
        #1;
        chk("stall_idle.busy", m_busy_o, 1'b1);
        tick();
        chk("stall_idle.req", dmem.req, 1'b0);
        chk("stall_idle.W_hold", W_icode_o, IOPQ);
        W_stall_i = 1'b0;

        mem_case("rmmovq", IRMMOVQ, 64'h50, 64'h100, 64'hDEAD, RNONE, RNONE, 2, 64'h0, 1'b0,
                 64'h100, 1'b1, 4);
        mem_case("mrmovq", IMRMOVQ, 64'h5a, 64'h200, 64'h0, RNONE, 4'h3, 0, 64'h1234, 1'b0,
                 64'h200, 1'b0, 2);
        mem_case("popq", IPOPQ, 64'h64, 64'h10, 64'h8, 4'h4, 4'h6, 1, 64'hABC, 1'b0,
                 64'h8, 1'b0, 3);
        mem_case("err", IMRMOVQ, 64'h66, 64'h1FF8, 64'h0, RNONE, 4'h1, 1, 64'hBAD, 1'b1,
                 64'h1FF8, 1'b0, 3);
        mem_case("call", ICALL, 64'h70, 64'h80, 64'h44, 4'h4, RNONE, 0, 64'h0, 1'b0,
                 64'h80, 1'b1, 2);
        mem_case("ret", IRET, 64'h79, 64'h88, 64'h500, 4'h4, RNONE, 3, 64'h1234_5678, 1'b0,
                 64'h500, 1'b0, 5);

        set_m(SAOK, IMRMOVQ, 64'h90, 64'h300, 64'h0, RNONE, 4'h5);
        tick();
        chk("stall_done.req", dmem.req, 1'b1);
        dmem.ack = 1'b1; dmem.rdata = 64'h55;
        tick();
        dmem.ack = 1'b0; dmem.rdata = '0;
        W_stall_i = 1'b1;
        #1;
        chk("stall_done.busy", m_busy_o, 1'b1);
        tick();
        chk("stall_done.W_hold", W_icode_o, INOP);
        chk("stall_done.busy2", m_busy_o, 1'b1);
        chk("stall_done.req_low", dmem.req, 1'b0);
        W_stall_i = 1'b0;
        #1;
        chk("stall_done.busy_rel", m_busy_o, 1'b0);
        tick();
        nop();
        chk_w("stall_done", SAOK, 64'h90, IMRMOVQ, 64'h300, 64'h55, RNONE, 4'h5);

        set_m(SAOK, IMRMOVQ, 64'hA0, 64'h400, 64'h0, RNONE, 4'h7);
        tick();
        chk("rst_wait.req_before", dmem.req, 1'b1);
        rst_n_i = 1'b0;
        #1;
        chk("rst_wait.req", dmem.req, 1'b0);
        chk("rst_wait.busy", m_busy_o, 1'b0);
        chk("rst_wait.W_icode", W_icode_o, INOP);
        nop();
        dmem.ack = 1'b1; dmem.rdata = 64'hF00D;
        tick();
        rst_n_i = 1'b1;
        tick();
        chk("late_ack.req", dmem.req, 1'b0);
        chk("late_ack.busy", m_busy_o, 1'b0);
        chk_w("late_ack", SAOK, 64'd0, INOP, 64'd0, 64'd0, RNONE, RNONE);
        dmem.ack = 1'b0; dmem.rdata = '0;

        set_m(SAOK, IOPQ, 64'hB0, 64'h1, 64'h0, 4'h2, RNONE);
        tick();
        chk("b2b0.W_pc", W_pc_o, 64'hB0);
        set_m(SAOK, IOPQ, 64'hB2, 64'h2, 64'h0, 4'h3, RNONE);
        tick();
        chk("b2b1.W_pc", W_pc_o, 64'hB2);
        chk("b2b1.W_valE", W_valE_o, 64'h2);
        chk("b2b1.req", dmem.req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
